// File: rtl/pipe_decode_pkg.sv
// Shared decode constants: RV32I opcodes and the decoded-instruction packet
// handed between pipeline stages.
package pipe_decode_pkg;

   localparam int XLEN = 32;
   localparam int PC_W = 32;

   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic [XLEN-1:0] insn;
      logic [6:0]      opcode;
      logic [4:0]      rd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [6:0]      funct7;
      logic [2:0]      funct3;
      logic [4:0]      shamt;
      logic [XLEN-1:0] imm;
      logic            rs1_used;
      logic            rs2_used;
      logic            rd_we;
   } decode_pkt_t;

   function automatic logic is_rv32i_opcode(input logic [6:0] opc);
      case (opc)
         OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM, OPC_AUIPC, OPC_STORE, OPC_OP,
         OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYSTEM: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/pipe_decode_igen.sv
// RV32I immediate generator: sign-extended I/S/B/U/J immediate selected by opcode.
// Purely combinational; formats without an immediate yield zero.
module pipe_decode_igen
   import pipe_decode_pkg::*;
(
   input  logic [XLEN-1:0] insn,
   output logic [XLEN-1:0] imm
);

   always_comb begin
      imm = '0;
      case (insn[6:0])
         OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_MISC_MEM, OPC_SYSTEM:
            imm = {{20{insn[31]}}, insn[31:20]};
         OPC_STORE:
            imm = {{20{insn[31]}}, insn[31:25], insn[11:7]};
         OPC_BRANCH:
            imm = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
         OPC_LUI, OPC_AUIPC:
            imm = {insn[31:12], 12'b0};
         OPC_JAL:
            imm = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
         default:
            imm = '0;
      endcase
   end

endmodule

// File: rtl/pipe_decode.sv
// RV32I decode stage: registered decode packet, 1-cycle latency, flush on branch redirect.
// Backpressure: output register plus one skid entry; in_ready_o is registered as !skid_vld.
// Optional illegal-instruction check enabled by defining PIPE_DECODE_ILLEGAL_CHECK_EN.
module pipe_decode
   import pipe_decode_pkg::*;
#(
   parameter int DWIDTH    = 32,
   parameter int AWIDTH    = 32,
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [AWIDTH-1:0]    pc_i,
   input  logic [DWIDTH-1:0]    insn_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output decode_pkt_t          dec_o,
   output logic                 illegal_o,
   output logic [CNT_WIDTH-1:0] decoded_count_o
);

   logic [XLEN-1:0] insn_w;
   logic [XLEN-1:0] imm_w;
   logic [6:0]      opc;
   logic            st_br;
   logic            uses_rs2;
   decode_pkt_t     dec_nxt;

   logic            out_vld;
   logic            skid_vld;
   decode_pkt_t     skid_dat;
   logic            acc;
   logic            out_hs;
   logic            out_free;

   assign insn_w = XLEN'(insn_i);
   assign opc    = insn_w[6:0];

   pipe_decode_igen u_igen (
      .insn (insn_w),
      .imm  (imm_w)
   );

   assign st_br    = (opc == OPC_STORE) || (opc == OPC_BRANCH);
   assign uses_rs2 = st_br || (opc == OPC_OP);

   always_comb begin
      dec_nxt          = '0;
      dec_nxt.pc       = PC_W'(pc_i);
      dec_nxt.insn     = insn_w;
      dec_nxt.opcode   = opc;
      dec_nxt.rd       = st_br ? 5'd0 : insn_w[11:7];
      dec_nxt.rs1      = insn_w[19:15];
      dec_nxt.rs2      = uses_rs2 ? insn_w[24:20] : 5'd0;
      dec_nxt.funct3   = insn_w[14:12];
      dec_nxt.shamt    = insn_w[24:20];
      dec_nxt.imm      = imm_w;
      dec_nxt.rs1_used = !((opc == OPC_LUI) || (opc == OPC_AUIPC) || (opc == OPC_JAL));
      dec_nxt.rs2_used = uses_rs2;
      dec_nxt.rd_we    = !st_br && (insn_w[11:7] != 5'd0);
      if ((opc == OPC_OP) || ((opc == OPC_OP_IMM) && (insn_w[14:12] == 3'b101)))
         dec_nxt.funct7 = insn_w[31:25];
   end

   // flush wins over accept; a same-cycle output handshake is still counted
   assign acc      = in_valid_i && in_ready_o && !flush_i;
   assign out_hs   = out_vld && out_ready_i;
   assign out_free = !out_vld || out_ready_i;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_vld         <= 1'b0;
         skid_vld        <= 1'b0;
         dec_o           <= '0;
         skid_dat        <= '0;
         decoded_count_o <= '0;
      end else begin
         if (out_hs)
            decoded_count_o <= decoded_count_o + CNT_WIDTH'(1);
         if (flush_i) begin
            out_vld  <= 1'b0;
            skid_vld <= 1'b0;
            dec_o    <= '0;
         end else if (out_free) begin
            if (skid_vld) begin
               out_vld  <= 1'b1;
               dec_o    <= skid_dat;
               skid_vld <= 1'b0;
            end else if (acc) begin
               out_vld <= 1'b1;
               dec_o   <= dec_nxt;
            end else begin
               out_vld <= 1'b0;
               dec_o   <= '0;
            end
         end else if (acc) begin
            skid_vld <= 1'b1;
            skid_dat <= dec_nxt;
         end
      end
   end

   assign in_ready_o  = !skid_vld;
   assign out_valid_o = out_vld;

`ifdef PIPE_DECODE_ILLEGAL_CHECK_EN
   logic ill_nxt;
   logic out_ill;
   logic skid_ill;

   // SUB/SRA are the only OP encodings allowed a non-zero funct7
   always_comb begin
      ill_nxt = (insn_w[1:0] != 2'b11) || !is_rv32i_opcode(opc);
      if (opc == OPC_OP) begin
         if (!((insn_w[31:25] == 7'b0000000) ||
               ((insn_w[31:25] == 7'b0100000) &&
                ((insn_w[14:12] == 3'b000) || (insn_w[14:12] == 3'b101)))))
            ill_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_ill  <= 1'b0;
         skid_ill <= 1'b0;
      end else if (flush_i) begin
         out_ill <= 1'b0;
      end else if (out_free) begin
         if (skid_vld)
            out_ill <= skid_ill;
         else if (acc)
            out_ill <= ill_nxt;
         else
            out_ill <= 1'b0;
      end else if (acc) begin
         skid_ill <= ill_nxt;
      end
   end

   assign illegal_o = out_ill;
`else
   assign illegal_o = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_decode.sv
// Randomized bench for pipe_decode against a queue-based occupancy model and a
// decode reference computed from the RV32I field rules.
module tb_pipe_decode;
   import pipe_decode_pkg::*;

   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst, flush_i, in_valid_i, in_ready_o, out_valid_o, out_ready_i, illegal_o;
   logic [31:0]   pc_i, insn_i;
   decode_pkt_t   dec_o;
   logic [CW-1:0] decoded_count_o;

   pipe_decode #(.DWIDTH(32), .AWIDTH(32), .CNT_WIDTH(CW)) dut (
      .clk             (clk),
      .rst             (rst),
      .flush_i         (flush_i),
      .in_valid_i      (in_valid_i),
      .in_ready_o      (in_ready_o),
      .pc_i            (pc_i),
      .insn_i          (insn_i),
      .out_valid_o     (out_valid_o),
      .out_ready_i     (out_ready_i),
      .dec_o           (dec_o),
      .illegal_o       (illegal_o),
      .decoded_count_o (decoded_count_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      decode_pkt_t p;
      logic        ill;
   } exp_t;

   exp_t        mq[$];
   int          mcnt;
   int          n_vec = 0;
   int          n_bad = 0;
   logic [6:0]  legal_ops[11] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33,
                                  7'h37, 7'h63, 7'h67, 7'h6F, 7'h73};

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic exp_t ref_decode(input logic [31:0] pc, input logic [31:0] w);
      exp_t       e;
      logic [6:0] op;
      logic [2:0] f3;
      logic       in_set;
      int         v;
      e  = '0;
      op = w[6:0];
      f3 = w[14:12];
      e.p.pc     = pc;
      e.p.insn   = w;
      e.p.opcode = op;
      e.p.funct3 = f3;
      e.p.rs1    = w[19:15];
      e.p.shamt  = w[24:20];
      e.p.rd     = (op == 7'h23 || op == 7'h63) ? 5'd0 : w[11:7];
      e.p.rs2    = (op == 7'h33 || op == 7'h23 || op == 7'h63) ? w[24:20] : 5'd0;
      e.p.funct7 = (op == 7'h33 || (op == 7'h13 && f3 == 3'd5)) ? w[31:25] : 7'd0;
      e.p.rs1_used = !(op == 7'h37 || op == 7'h17 || op == 7'h6F);
      e.p.rs2_used = (op == 7'h33 || op == 7'h23 || op == 7'h63);
      e.p.rd_we    = !(op == 7'h23 || op == 7'h63) && (w[11:7] != 0);
      v = 0;
      case (op)
         7'h03, 7'h13, 7'h67, 7'h0F, 7'h73: v = int'(w[31:20]) - (w[31] ? 4096 : 0);
         7'h23: v = int'({w[31:25], w[11:7]}) - (w[31] ? 4096 : 0);
         7'h63: v = -4096 * int'(w[31]) + 2048 * int'(w[7]) + 32 * int'(w[30:25]) + 2 * int'(w[11:8]);
         7'h37, 7'h17: v = int'(w & 32'hFFFFF000);
         7'h6F: v = -1048576 * int'(w[31]) + 4096 * int'(w[19:12]) + 2048 * int'(w[20]) + 2 * int'(w[30:21]);
         default: v = 0;
      endcase
      e.p.imm = v;
      in_set = 1'b0;
      foreach (legal_ops[k]) if (legal_ops[k] == op) in_set = 1'b1;
`ifdef PIPE_DECODE_ILLEGAL_CHECK_EN
      e.ill = (w[1:0] != 2'b11) || !in_set ||
              (op == 7'h33 && !(w[31:25] == 7'h00 ||
                                (w[31:25] == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))));
`else
      e.ill = 1'b0;
`endif
      return e;
   endfunction

   function automatic logic [31:0] rand_insn();
      logic [31:0] w;
      int          r;
      w = $urandom();
      r = $urandom_range(0, 9);
      if (r == 0) begin
         w = 32'hFFFF_FFFF;
      end else if (r > 1) begin
         w[6:0] = legal_ops[$urandom_range(0, 10)];
         if (w[6:0] == 7'h33 && $urandom_range(0, 2) != 0)
            w[31:25] = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20;
      end
      return w;
   endfunction

   task automatic check_all();
      exp_t front;
      front = (mq.size() > 0) ? mq[0] : '0;
      chk("out_valid", out_valid_o, mq.size() > 0);
      chk("in_ready", in_ready_o, mq.size() < 2);
      chk("dec", dec_o, front.p);
      chk("illegal", illegal_o, front.ill);
      chk("count", decoded_count_o, mcnt);
   endtask

   // Inputs are applied just after a falling edge; the model advances for the
   // coming rising edge, and outputs are compared on the next falling edge.
   task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] insn,
                       input logic ordy, input logic fl, input logic r);
      logic hs, acc;
      in_valid_i  = v;
      pc_i        = pc;
      insn_i      = insn;
      out_ready_i = ordy;
      flush_i     = fl;
      rst         = r;
      if (r) begin
         mq.delete();
         mcnt = 0;
      end else begin
         hs  = (mq.size() > 0) && ordy;
         acc = v && (mq.size() < 2) && !fl;
         if (hs) mcnt = (mcnt + 1) % (1 << CW);
         if (fl) mq.delete();
         else begin
            if (hs) void'(mq.pop_front());
            if (acc) mq.push_back(ref_decode(pc, insn));
         end
      end
      @(negedge clk);
      check_all();
   endtask

   initial begin
      int c0;
      mcnt = 0;
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 1, 0, 0);

      step(1, 32'h100, 32'h0050_0093, 1, 0, 0);
      chk("addi_vld", out_valid_o, 1);
      chk("addi_rd", dec_o.rd, 1);
      chk("addi_rs1", dec_o.rs1, 0);
      chk("addi_rs2", dec_o.rs2, 0);
      chk("addi_imm", dec_o.imm, 5);
      chk("addi_rs1u", dec_o.rs1_used, 1);
      chk("addi_rdwe", dec_o.rd_we, 1);
      chk("addi_pc", dec_o.pc, 32'h100);

      step(1, 32'h104, 32'h0020_A423, 1, 0, 0);
      chk("sw_rd", dec_o.rd, 0);
      chk("sw_rs1", dec_o.rs1, 1);
      chk("sw_rs2", dec_o.rs2, 2);
      chk("sw_imm", dec_o.imm, 8);
      chk("sw_rdwe", dec_o.rd_we, 0);
      chk("sw_rs2u", dec_o.rs2_used, 1);
      step(0, 0, 0, 1, 0, 0);

      step(1, 32'h200, 32'h0010_0093, 0, 0, 0);
      chk("stall_a", dec_o.insn, 32'h0010_0093);
      step(1, 32'h204, 32'h0020_0113, 0, 0, 0);
      chk("stall_rdy", in_ready_o, 0);
      step(1, 32'h208, 32'h0030_0193, 0, 0, 0);
      chk("stall_hold", dec_o.insn, 32'h0010_0093);
      c0 = mcnt;
      step(1, 32'h208, 32'h0030_0193, 1, 0, 0);
      chk("drain_b", dec_o.insn, 32'h0020_0113);
      step(1, 32'h208, 32'h0030_0193, 1, 0, 0);
      chk("drain_c", dec_o.insn, 32'h0030_0193);
      step(0, 0, 0, 1, 0, 0);
      chk("drain_cnt", decoded_count_o, (c0 + 3) % (1 << CW));

      step(1, 32'h300, 32'h0010_0093, 0, 0, 0);
      step(1, 32'h304, 32'h0020_0113, 0, 0, 0);
      c0 = mcnt;
      step(1, 32'h308, 32'h0030_0193, 0, 1, 0);
      chk("flush_vld", out_valid_o, 0);
      chk("flush_rdy", in_ready_o, 1);
      chk("flush_cnt", decoded_count_o, c0);

      step(1, 32'h400, 32'hFFFF_FFFF, 1, 0, 0);
`ifdef PIPE_DECODE_ILLEGAL_CHECK_EN
      chk("ffff_ill", illegal_o, 1);
`else
      chk("ffff_ill", illegal_o, 0);
`endif
      step(0, 0, 0, 1, 0, 0);

      step(0, 0, 0, 1, 0, 1);
      for (int i = 0; i < 17; i++) step(1, 32'h500 + 4 * i, 32'h0000_0013, 1, 0, 0);
      step(0, 0, 0, 1, 0, 0);
      chk("wrap17", decoded_count_o, 1);

      for (int i = 0; i < 2000; i++)
         step($urandom_range(0, 9) < 7, $urandom(), rand_insn(), $urandom_range(0, 9) < 6,
              $urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
